reg_mem: RTL and testbench
==========================

REG_MEM -- requirements
Module: reg_mem

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each stored word and of data_in/data_out.
REQ-002 Parameter ADDR_BITS, default 5: address width; depth = 2**ADDR_BITS words (32 by default).
REQ-003 Port clk, input, 1: single clock; all sequential logic on rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port addr, input, ADDR_BITS: shared read/write word address.
REQ-006 Port data_in, input, DATA_WIDTH: write data.
REQ-007 Port wen, input, 1: write enable, active-high; 0 = read.
REQ-008 Port data_out, output, DATA_WIDTH: registered read data.
REQ-009 Port declaration order SHALL be addr, data_in, wen, clk, data_out, rst, so existing positional instantiations keep their mapping; rst is appended last.
REQ-010 Parameters SHALL be declared in order DATA_WIDTH, ADDR_BITS, so positional parameter overrides work.

Function
REQ-011 Storage SHALL be 2**ADDR_BITS words of DATA_WIDTH bits, implemented as flip-flops, not inferred RAM, because reset must clear every word.
REQ-012 Rising clk with wen=1 and rst=0: mem[addr] <= data_in; all other words unchanged.
REQ-013 Rising clk with wen=0 and rst=0: data_out <= mem[addr]; memory unchanged.
REQ-014 Rising clk with wen=1: data_out SHALL hold its previous value; no write-through.
REQ-015 Read latency SHALL be exactly 1 clock: data_out reflects the addr sampled at the most recent rising edge with wen=0.
REQ-016 Write then read of the same address SHALL return the written data on the first read edge after the write edge.
REQ-017 All addr values 0..2**ADDR_BITS-1 SHALL be valid; there is no out-of-range condition and no wrap logic.
REQ-018 Inputs are sampled only at rising clk; changes between edges SHALL NOT affect memory or data_out.
REQ-019 Any X on wen SHALL NOT be treated as a write in synthesis; simulation behaviour for X inputs is unspecified.

Reset
REQ-020 rst=1 SHALL immediately clear every memory word and data_out to 0, without waiting for a clock edge.
REQ-021 While rst=1, clock edges SHALL have no effect: no write and no data_out update.
REQ-022 A write whose edge coincides with rst assertion SHALL be lost; the reset value wins.
REQ-023 After rst deasserts, the first rising clk SHALL operate normally; no extra recovery cycles.
REQ-024 Reset mid-sequence SHALL discard all prior contents; subsequent reads return 0 until a location is rewritten.

Structure
REQ-025 No shared package is required; DATA_WIDTH and ADDR_BITS SHALL remain module parameters, and the depth SHALL be derived locally as 1<<ADDR_BITS.
REQ-026 The module SHALL be a single flat module with no sub-modules; the optional address decoder SHALL be coded inline.

Verification
REQ-027 Reset: assert rst asynchronously between edges -> data_out==0 immediately; after release, reads of addresses 0, 15 and 31 return 0.
REQ-028 Fill and readback: with wen=1, write i+10 to address i for i=0..31 (one edge each); then with wen=0 read addresses 0..31 -> data_out equals 10..41, one cycle after each address edge.
REQ-029 Hold during write: read address 5 (data_out=15), then write 99 to address 5 -> data_out stays 15 until the next read edge, which returns 99.
REQ-030 Isolation: write 0xAA to address 31 and 0x55 to address 0 -> address 30 still reads 40 (from the fill) and address 1 still reads 11.
REQ-031 Reset mid-operation: after the fill, pulse rst for 3 ns with no clock edge -> a read of address 20 returns 0, not 30.
REQ-032 Parameter override: DATA_WIDTH=16, ADDR_BITS=3 -> write 0xBEEF to address 7 and 0x1234 to address 0; reads return the exact 16-bit values.

Source files
------------

// File: rtl/reg_mem_pkg.sv
// Shared defaults for the flop-based register memory.
package reg_mem_pkg;
    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_ADDR_BITS  = 5;
endpackage

// File: rtl/reg_mem.sv
// reg_mem: flop-based word memory with async clear, one shared read/write address.
// Read latency 1 clk; data_out holds during writes; no backpressure.
module reg_mem
    import reg_mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_BITS  = DEF_ADDR_BITS
) (
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wen,
    input  logic                  clk,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  rst
);

    localparam int DEPTH = 1 << ADDR_BITS;

    // Flops rather than RAM so reset can clear every word at once.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_out_q;
    logic [DATA_WIDTH-1:0] data_out_d;

    always_comb begin
        mem_d      = mem_q;
        data_out_d = data_out_q;
        if (wen == 1'b1) begin
            mem_d[addr] = data_in;
        end else begin
            data_out_d = mem_q[addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            data_out_q <= '0;
        end else begin
            mem_q      <= mem_d;
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_reg_mem.sv
// Directed bench for reg_mem: default instance plus a 16-bit/8-deep override.
module tb_reg_mem;

    logic       clk;
    logic       rst;
    logic [4:0] addr;
    logic [7:0] data_in;
    logic       wen;
    logic [7:0] data_out;

    logic [2:0]  addr2;
    logic [15:0] data_in2;
    logic        wen2;
    logic [15:0] data_out2;

    int checks;
    int errors;

    reg_mem dut (
        .addr     (addr),
        .data_in  (data_in),
        .wen      (wen),
        .clk      (clk),
        .data_out (data_out),
        .rst      (rst)
    );

    reg_mem #(.DATA_WIDTH(16), .ADDR_BITS(3)) dut2 (
        .addr     (addr2),
        .data_in  (data_in2),
        .wen      (wen2),
        .clk      (clk),
        .data_out (data_out2),
        .rst      (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are checked on the next falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        addr = a; data_in = d; wen = 1'b1;
        step();
        wen = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a);
        addr = a; wen = 1'b0;
        step();
    endtask

    task automatic test_reset();
        logic [4:0] zaddr [3];
        zaddr[0] = 5'd0; zaddr[1] = 5'd15; zaddr[2] = 5'd31;
        checks++;
        if (data_out !== 8'h00 || data_out2 !== 16'h0000) begin
            errors++;
            $display("FAIL reset_initial: got %h/%h, expected 00/0000", data_out, data_out2);
        end
        wr(5'd3, 8'h07);
        rd(5'd3);
        checks++;
        if (data_out !== 8'h07) begin
            errors++;
            $display("FAIL reset_preload: got %h, expected 07", data_out);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_async_clear: got %h, expected 00", data_out);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rd(zaddr[i]);
            checks++;
            if (data_out !== 8'h00) begin
                errors++;
                $display("FAIL reset_read addr %0d: got %h, expected 00", zaddr[i], data_out);
            end
        end
        rd(5'd3);
        checks++;
        if (data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_cleared_word: got %h, expected 00", data_out);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 32; i++) begin
            wr(5'(i), 8'(i + 10));
        end
        for (int i = 0; i < 32; i++) begin
            rd(5'(i));
            checks++;
            if (data_out !== 8'(i + 10)) begin
                errors++;
                $display("FAIL fill_readback addr %0d: got %0d, expected %0d", i, data_out, i + 10);
            end
        end
    endtask

    task automatic test_hold_during_write();
        rd(5'd5);
        checks++;
        if (data_out !== 8'd15) begin
            errors++;
            $display("FAIL hold_pre_read: got %0d, expected 15", data_out);
        end
        wr(5'd5, 8'd99);
        checks++;
        if (data_out !== 8'd15) begin
            errors++;
            $display("FAIL hold_during_write: got %0d, expected 15", data_out);
        end
        rd(5'd5);
        checks++;
        if (data_out !== 8'd99) begin
            errors++;
            $display("FAIL hold_post_read: got %0d, expected 99", data_out);
        end
    endtask

    task automatic test_isolation();
        wr(5'd31, 8'hAA);
        wr(5'd0, 8'h55);
        rd(5'd30);
        checks++;
        if (data_out !== 8'd40) begin
            errors++;
            $display("FAIL iso_addr30: got %0d, expected 40", data_out);
        end
        rd(5'd1);
        checks++;
        if (data_out !== 8'd11) begin
            errors++;
            $display("FAIL iso_addr1: got %0d, expected 11", data_out);
        end
        rd(5'd31);
        checks++;
        if (data_out !== 8'hAA) begin
            errors++;
            $display("FAIL iso_addr31: got %h, expected aa", data_out);
        end
        rd(5'd0);
        checks++;
        if (data_out !== 8'h55) begin
            errors++;
            $display("FAIL iso_addr0: got %h, expected 55", data_out);
        end
    endtask

    task automatic test_back_to_back();
        wr(5'd9, 8'h12);
        rd(5'd9);
        checks++;
        if (data_out !== 8'h12) begin
            errors++;
            $display("FAIL b2b_write_read: got %h, expected 12", data_out);
        end
        // Wiggle inputs between edges; nothing may change until a clock edge.
        addr = 5'd2; data_in = 8'hFF; wen = 1'b1;
        #2;
        checks++;
        if (data_out !== 8'h12) begin
            errors++;
            $display("FAIL glitch_no_edge: got %h, expected 12", data_out);
        end
        wen = 1'b0;
        @(negedge clk);
        checks++;
        if (data_out !== 8'd12) begin
            errors++;
            $display("FAIL glitch_mem_intact: got %0d, expected 12", data_out);
        end
    endtask

    task automatic test_reset_mid();
        #1 rst = 1'b1;
        #3 rst = 1'b0;
        @(negedge clk);
        rd(5'd20);
        checks++;
        if (data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_addr20: got %0d, expected 0", data_out);
        end
        // Write edges while reset is held must be lost.
        addr = 5'd4; data_in = 8'h33; wen = 1'b1; rst = 1'b1;
        step();
        step();
        wen = 1'b0;
        #2 rst = 1'b0;
        @(negedge clk);
        rd(5'd4);
        checks++;
        if (data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_blocks_write: got %h, expected 00", data_out);
        end
        wr(5'd4, 8'h44);
        rd(5'd4);
        checks++;
        if (data_out !== 8'h44) begin
            errors++;
            $display("FAIL post_reset_first_edge: got %h, expected 44", data_out);
        end
    endtask

    task automatic test_params();
        addr2 = 3'd7; data_in2 = 16'hBEEF; wen2 = 1'b1;
        step();
        addr2 = 3'd0; data_in2 = 16'h1234;
        step();
        wen2 = 1'b0; addr2 = 3'd7;
        step();
        checks++;
        if (data_out2 !== 16'hBEEF) begin
            errors++;
            $display("FAIL param_addr7: got %h, expected beef", data_out2);
        end
        addr2 = 3'd0;
        step();
        checks++;
        if (data_out2 !== 16'h1234) begin
            errors++;
            $display("FAIL param_addr0: got %h, expected 1234", data_out2);
        end
        addr2 = 3'd3;
        step();
        checks++;
        if (data_out2 !== 16'h0000) begin
            errors++;
            $display("FAIL param_addr3: got %h, expected 0000", data_out2);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        addr = '0; data_in = '0; wen = 1'b0;
        addr2 = '0; data_in2 = '0; wen2 = 1'b0;
        #12 rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_fill();
        test_hold_during_write();
        test_isolation();
        test_back_to_back();
        test_reset_mid();
        test_params();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
